// File: rtl/set_arb_pkg.sv
// Shared types and constants for the set-query arbiter: FSM states, engine mode
// codes, and field layout of the packed central/radius query words.
package set_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } arb_state_t;

  localparam logic [1:0] MODE_A   = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W  = 12;
  localparam int COORD_W   = 4;

  // central = {x1, y1, x2, y2, 8'b0}; radius = {r1, r2, 4'b0}
  localparam int X1_LSB = 20;
  localparam int Y1_LSB = 16;
  localparam int X2_LSB = 12;
  localparam int Y2_LSB = 8;
  localparam int R1_LSB = 8;
  localparam int R2_LSB = 4;

endpackage

// File: rtl/set_query_arbiter_if.sv
// Bundle of requester, engine and response signals around set_query_arbiter.
// slave = arbiter view, master = requesters/engine view.
interface set_query_arbiter_if
  import set_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) ();

  logic [NREQ-1:0]           req_valid;
  logic [CENTRAL_W*NREQ-1:0] req_central;
  logic [RADIUS_W*NREQ-1:0]  req_radius;
  logic [2*NREQ-1:0]         req_mode;
  logic [NREQ-1:0]           req_ready;

  logic                      eng_en;
  logic [CENTRAL_W-1:0]      eng_central;
  logic [RADIUS_W-1:0]       eng_radius;
  logic [1:0]                eng_mode;
  logic                      eng_busy;
  logic                      eng_valid;
  logic [7:0]                eng_candidate;

  logic                      rsp_valid;
  logic [IDW-1:0]            rsp_id;
  logic [7:0]                rsp_candidate;
  logic                      rsp_err;
  logic                      arb_busy;

  modport slave (
    input  req_valid, req_central, req_radius, req_mode,
    output req_ready,
    output eng_en, eng_central, eng_radius, eng_mode,
    input  eng_busy, eng_valid, eng_candidate,
    output rsp_valid, rsp_id, rsp_candidate, rsp_err, arb_busy
  );

  modport master (
    output req_valid, req_central, req_radius, req_mode,
    input  req_ready,
    input  eng_en, eng_central, eng_radius, eng_mode,
    output eng_busy, eng_valid, eng_candidate,
    input  rsp_valid, rsp_id, rsp_candidate, rsp_err, arb_busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping
// modulo NREQ; returns a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic found;
  int   pos;

  assign any = |req;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves a latch.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/set_query_arbiter.sv
// Round-robin front end sharing one circle-set counting engine among NREQ
// requesters. Optional WAIT timeout abort enabled by SET_ARB_TIMEOUT_EN.
module set_query_arbiter
  import set_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 63
) (
  input logic              clk,
  input logic              rst,
  set_query_arbiter_if.slave bus
);

  if (IDW != $clog2(NREQ) || NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("set_query_arbiter: inconsistent NREQ/IDW/TIMEOUT");
  end

  arb_state_t      state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id_q;
  logic            seen_busy;
  logic [NREQ-1:0] win_gnt;
  logic [IDW-1:0]  win_idx;
  logic [IDW-1:0]  ptr_next;
  logic            win_any;
  logic [1:0]      win_mode;
  logic            done;

`ifdef SET_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  assign win_mode = bus.req_mode[2*int'(win_idx) +: 2];
  assign ptr_next = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
  // Busy must have been seen first so a level-sticky eng_valid is not taken as the result.
  assign done     = seen_busy && !bus.eng_busy && bus.eng_valid;

  // Accept is same-cycle with the grant decision so the fields latch on this edge.
  assign bus.req_ready = (state == S_IDLE && !rst) ? win_gnt : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      ptr               <= '0;
      id_q              <= '0;
      seen_busy         <= 1'b0;
`ifdef SET_ARB_TIMEOUT_EN
      to_cnt            <= '0;
`endif
      bus.eng_en        <= 1'b0;
      bus.eng_central   <= '0;
      bus.eng_radius    <= '0;
      bus.eng_mode      <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_id        <= '0;
      bus.rsp_candidate <= '0;
      bus.rsp_err       <= 1'b0;
      bus.arb_busy      <= 1'b0;
    end else begin
      bus.eng_en    <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_any) begin
            ptr             <= ptr_next;
            id_q            <= win_idx;
            bus.eng_central <= bus.req_central[int'(win_idx)*CENTRAL_W +: CENTRAL_W];
            bus.eng_radius  <= bus.req_radius[int'(win_idx)*RADIUS_W +: RADIUS_W];
            bus.eng_mode    <= win_mode;
            bus.arb_busy    <= 1'b1;
            if (win_mode == MODE_ILL) begin
              state             <= S_RESP;
              bus.rsp_valid     <= 1'b1;
              bus.rsp_id        <= win_idx;
              bus.rsp_candidate <= '0;
              bus.rsp_err       <= 1'b1;
            end else begin
              state      <= S_ISSUE;
              bus.eng_en <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state     <= S_WAIT;
          seen_busy <= 1'b0;
`ifdef SET_ARB_TIMEOUT_EN
          to_cnt    <= '0;
`endif
        end
        S_WAIT: begin
          if (bus.eng_busy) seen_busy <= 1'b1;
          if (done) begin
            state             <= S_RESP;
            bus.rsp_valid     <= 1'b1;
            bus.rsp_id        <= id_q;
            bus.rsp_candidate <= bus.eng_candidate;
            bus.rsp_err       <= 1'b0;
          end
`ifdef SET_ARB_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            state             <= S_RESP;
            bus.rsp_valid     <= 1'b1;
            bus.rsp_id        <= id_q;
            bus.rsp_candidate <= '0;
            bus.rsp_err       <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          state        <= S_IDLE;
          bus.arb_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_query_arbiter.sv
// Directed bench for set_query_arbiter with a geometric engine model and a
// transaction-level reference (round-robin pick, expected response queue).
module tb_set_query_arbiter;
  import set_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TO   = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  set_query_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  set_query_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Count of 8x8 grid points inside circle A, A and B, or exactly one of them.
  function automatic int geo_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int x1, y1, x2, y2, r1, r2, n;
    bit a, b, hit;
    x1 = int'(c[X1_LSB +: COORD_W]);
    y1 = int'(c[Y1_LSB +: COORD_W]);
    x2 = int'(c[X2_LSB +: COORD_W]);
    y2 = int'(c[Y2_LSB +: COORD_W]);
    r1 = int'(r[R1_LSB +: COORD_W]);
    r2 = int'(r[R2_LSB +: COORD_W]);
    n  = 0;
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        a = ((x - x1) * (x - x1) + (y - y1) * (y - y1)) <= r1 * r1;
        b = ((x - x2) * (x - x2) + (y - y2) * (y - y2)) <= r2 * r2;
        case (m)
          MODE_A:   hit = a;
          MODE_AND: hit = a && b;
          MODE_XOR: hit = a ^ b;
          default:  hit = 1'b0;
        endcase
        if (hit) n++;
      end
    end
    return n;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  typedef struct {
    int id;
    int cand;
    bit err;
  } rsp_t;

  // Bench-side copies of the driven query fields
  logic [23:0] q_c [NREQ];
  logic [11:0] q_r [NREQ];
  logic [1:0]  q_m [NREQ];

  // Engine model controls
  int eng_lat    = 3;
  int eng_dly    = 0;
  bit eng_sticky = 1'b0;
  bit eng_stuck  = 1'b0;

  // Reference model state and logs
  rsp_t            exp_q[$];
  int              m_ptr = 0;
  bit              m_out = 1'b0;
  bit              en_due = 1'b0;
  logic [23:0]     x_c;
  logic [11:0]     x_r;
  logic [1:0]      x_m;
  logic [NREQ-1:0] gnt_seen = '0;
  int              cyc = 0;
  int              en_cnt = 0;
  int              rsp_cnt = 0;
  int              last_id, last_cand;
  bit              last_err;
  int              gnt_log[$];
  int              gnt_cyc_log[$];
  int              en_cyc_log[$];
  int              rsp_cyc_log[$];
  int              rsp_cand_log[$];
  int              rsp_err_log[$];

  // Engine model: busy for eng_lat cycles after an optional delay, then result.
  initial begin
    int cnt;
    bus.eng_busy      = 1'b0;
    bus.eng_valid     = 1'b0;
    bus.eng_candidate = '0;
    forever begin
      @(negedge clk);
      if (bus.eng_en) begin
        cnt = geo_count(bus.eng_central, bus.eng_radius, bus.eng_mode);
        @(posedge clk); #1;
        if (!eng_sticky) bus.eng_valid = 1'b0;
        repeat (eng_dly) begin @(posedge clk); #1; end
        bus.eng_busy = 1'b1;
        if (eng_stuck) begin
          wait (!eng_stuck);
          @(posedge clk); #1;
          bus.eng_busy = 1'b0;
        end else begin
          repeat (eng_lat) @(posedge clk);
          #1;
          bus.eng_busy      = 1'b0;
          bus.eng_valid     = 1'b1;
          bus.eng_candidate = 8'(cnt);
          if (!eng_sticky) begin
            @(posedge clk); #1;
            bus.eng_valid = 1'b0;
          end
        end
      end
    end
  end

  // Compare process: checks DUT outputs against the reference on every falling edge.
  initial begin
    int   g;
    bit   ill, err;
    rsp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        m_ptr    = 0;
        m_out    = 1'b0;
        en_due   = 1'b0;
        gnt_seen = '0;
        continue;
      end
      check("arb_busy", bus.arb_busy, m_out);
      gnt_seen = bus.req_ready;
      if (bus.req_ready != '0) begin
        g = rr_pick(bus.req_valid, m_ptr);
        check("grant_onehot", bus.req_ready, (g < 0) ? 0 : (1 << g));
        check("grant_while_busy", m_out, 1'b0);
        if (g >= 0) begin
          ill = (q_m[g] == MODE_ILL);
`ifdef SET_ARB_TIMEOUT_EN
          err = ill || eng_stuck;
`else
          err = ill;
`endif
          e.id   = g;
          e.cand = err ? 0 : geo_count(q_c[g], q_r[g], q_m[g]);
          e.err  = err;
          exp_q.push_back(e);
          m_ptr  = (g + 1) % NREQ;
          m_out  = 1'b1;
          en_due = !ill;
          x_c    = q_c[g];
          x_r    = q_r[g];
          x_m    = q_m[g];
          gnt_log.push_back(g);
          gnt_cyc_log.push_back(cyc);
        end
      end
      if (bus.eng_en) begin
        check("eng_en_due", en_due, 1'b1);
        check("eng_central", bus.eng_central, x_c);
        check("eng_radius", bus.eng_radius, x_r);
        check("eng_mode", bus.eng_mode, x_m);
        en_due = 1'b0;
        en_cnt++;
        en_cyc_log.push_back(cyc);
      end else if (m_out && !en_due && x_m != MODE_ILL) begin
        check("eng_central_hold", bus.eng_central, x_c);
        check("eng_radius_hold", bus.eng_radius, x_r);
      end
      if (bus.rsp_valid) begin
        check("rsp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_id", bus.rsp_id, e.id);
          check("rsp_candidate", bus.rsp_candidate, e.cand);
          check("rsp_err", bus.rsp_err, e.err);
          check("rsp_after_dispatch", en_due, 1'b0);
        end
        m_out     = 1'b0;
        last_id   = int'(bus.rsp_id);
        last_cand = int'(bus.rsp_candidate);
        last_err  = bus.rsp_err;
        rsp_cand_log.push_back(int'(bus.rsp_candidate));
        rsp_err_log.push_back(int'(bus.rsp_err));
        rsp_cyc_log.push_back(cyc);
        rsp_cnt++;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      bus.req_valid = bus.req_valid & ~gnt_seen;
    end
  endtask

  task automatic post(input int i, input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    q_c[i] = c;
    q_r[i] = r;
    q_m[i] = m;
    bus.req_central[i*CENTRAL_W +: CENTRAL_W] = c;
    bus.req_radius[i*RADIUS_W +: RADIUS_W]    = r;
    bus.req_mode[2*i +: 2]                    = m;
    bus.req_valid[i]                          = 1'b1;
  endtask

  task automatic wait_rsp(input string name, input int target, input int budget);
    for (int k = 0; k < budget && rsp_cnt < target; k++) step();
    check(name, rsp_cnt, target);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_eng_en"}, bus.eng_en, 0);
    check({tag, "_eng_central"}, bus.eng_central, 0);
    check({tag, "_eng_radius"}, bus.eng_radius, 0);
    check({tag, "_eng_mode"}, bus.eng_mode, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_id"}, bus.rsp_id, 0);
    check({tag, "_rsp_candidate"}, bus.rsp_candidate, 0);
    check({tag, "_rsp_err"}, bus.rsp_err, 0);
    check({tag, "_arb_busy"}, bus.arb_busy, 0);
  endtask

  localparam logic [23:0] C_AB  = 24'h446600;  // A at (4,4), B at (6,6)
  localparam logic [11:0] R_32  = 12'h320;     // r1=3, r2=2
  localparam logic [23:0] C_ORG = 24'h000000;
  localparam logic [11:0] R_20  = 12'h200;

  initial begin
    int base, en0;
    int exp_order[5];
    int exp_cand[5];
    exp_order = '{0, 1, 2, 3, 0};
    exp_cand  = '{29, 6, 28, 6, 29};

    rst             = 1'b1;
    bus.req_valid   = '0;
    bus.req_central = '0;
    bus.req_radius  = '0;
    bus.req_mode    = '0;
    for (int i = 0; i < NREQ; i++) begin
      q_c[i] = '0;
      q_r[i] = '0;
      q_m[i] = '0;
    end
    step(3);
    check_quiet("reset");
    rst = 1'b0;
    step(2);

    // Round robin from ptr=0, requester 0 re-requests after its grant
    gnt_log.delete();
    rsp_cand_log.delete();
    base = rsp_cnt;
    post(0, C_AB, R_32, MODE_A);
    post(1, C_AB, R_32, MODE_AND);
    post(2, C_AB, R_32, MODE_XOR);
    post(3, C_ORG, R_20, MODE_A);
    for (int k = 0; k < 50 && gnt_log.size() == 0; k++) step();
    post(0, C_AB, R_32, MODE_A);
    wait_rsp("rr_responses", base + 5, 400);
    check("rr_grant_count", gnt_log.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < gnt_log.size()) check("rr_order", gnt_log[k], exp_order[k]);
      if (k < rsp_cand_log.size()) check("rr_cand", rsp_cand_log[k], exp_cand[k]);
    end
    step(2);

    // Single query, requester 0 alone
    en0  = en_cnt;
    base = rsp_cnt;
    post(0, C_AB, R_32, MODE_A);
    wait_rsp("single_rsp", base + 1, 100);
    check("single_id", last_id, 0);
    check("single_cand", last_cand, 29);
    check("single_err", last_err, 1'b0);
    check("single_en_pulses", en_cnt - en0, 1);
    step(2);

    // Illegal mode: error response with no dispatch
    en0  = en_cnt;
    base = rsp_cnt;
    post(2, C_AB, R_32, MODE_ILL);
    wait_rsp("illegal_rsp", base + 1, 50);
    check("illegal_id", last_id, 2);
    check("illegal_err", last_err, 1'b1);
    check("illegal_cand", last_cand, 0);
    step(3);
    check("illegal_no_en", en_cnt - en0, 0);

    // Level-sticky engine valid: stale result must be ignored
    eng_sticky = 1'b1;
    base = rsp_cnt;
    post(1, C_AB, R_32, MODE_A);
    wait_rsp("sticky_first", base + 1, 100);
    check("sticky_first_cand", last_cand, 29);
    step(2);
    eng_dly = 3;
    post(3, C_ORG, R_20, MODE_A);
    wait_rsp("sticky_second", base + 2, 100);
    check("sticky_second_id", last_id, 3);
    check("sticky_second_cand", last_cand, 6);
    eng_sticky = 1'b0;
    eng_dly    = 0;
    step(2);

    // Reset during WAIT aborts silently and clears ptr
    eng_stuck = 1'b1;
    en0  = en_cnt;
    base = rsp_cnt;
    post(1, C_AB, R_32, MODE_A);
    for (int k = 0; k < 50 && en_cnt == en0; k++) step();
    step(2);
    rst = 1'b1;
    step();
    check_quiet("mid_reset");
    rst = 1'b0;
    step();
    check("mid_reset_no_rsp", rsp_cnt, base);
    eng_stuck = 1'b0;
    step(3);
    gnt_log.delete();
    post(1, C_AB, R_32, MODE_AND);
    post(3, C_ORG, R_20, MODE_A);
    wait_rsp("post_reset_rsp", base + 2, 200);
    check("post_reset_grants", gnt_log.size(), 2);
    if (gnt_log.size() >= 2) begin
      check("post_reset_first", gnt_log[0], 1);
      check("post_reset_second", gnt_log[1], 3);
    end
    check("post_reset_cand", last_cand, 6);
    step(2);

`ifdef SET_ARB_TIMEOUT_EN
    // Stuck engine: abort after TO cycles in WAIT, next requester granted right after
    eng_stuck = 1'b1;
    gnt_log.delete();
    gnt_cyc_log.delete();
    en_cyc_log.delete();
    rsp_cyc_log.delete();
    rsp_err_log.delete();
    base = rsp_cnt;
    post(0, C_AB, R_32, MODE_A);
    for (int k = 0; k < 50 && gnt_log.size() == 0; k++) step();
    post(2, C_AB, R_32, MODE_XOR);
    wait_rsp("timeout_rsp", base + 2, 200);
    if (en_cyc_log.size() >= 1 && rsp_cyc_log.size() >= 1)
      check("timeout_latency", rsp_cyc_log[0] - en_cyc_log[0], TO + 1);
    if (gnt_cyc_log.size() >= 2 && rsp_cyc_log.size() >= 1)
      check("timeout_next_grant", gnt_cyc_log[1] - rsp_cyc_log[0], 1);
    if (rsp_err_log.size() >= 1) check("timeout_err", rsp_err_log[0], 1);
    eng_stuck = 1'b0;
    step(5);
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, %0d checks so far", n_vec);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/set_query_arbiter.md
Name: set_query_arbiter

Overview:
- Shares one circle-set counting engine among NREQ requesters. The engine takes two centres, two radii and a mode, and returns the count of 8x8 grid points in A, A∩B or A⊕B.
- Arbitration is round-robin. The block latches the winning query, pulses the engine start, waits for completion and returns the count tagged with the requester id.
- Sits between the query sources and the single engine instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester id width, must equal clog2(NREQ)
- TIMEOUT, 63, max cycles in WAIT before abort (used only with SET_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NREQ  per-requester query pending
- req_central  in  24*NREQ  slice i = {x1,y1,x2,y2,8'b0} of requester i
- req_radius  in  12*NREQ  slice i = {r1,r2,4'b0}
- req_mode  in  2*NREQ  slice i: 00 A, 01 A∩B, 10 A⊕B, 11 illegal
- req_ready  out  NREQ  one-hot accept pulse to granted requester
- eng_en  out  1  engine start pulse
- eng_central  out  24  latched query to engine
- eng_radius  out  12  latched query to engine
- eng_mode  out  2  latched query to engine
- eng_busy  in  1  engine busy
- eng_valid  in  1  engine result valid
- eng_candidate  in  8  engine count
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  IDW  requester of response
- rsp_candidate  out  8  count (0 on error)
- rsp_err  out  1  illegal mode or timeout
- arb_busy  out  1  high in any state except IDLE

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. All outputs 0, state IDLE, rr pointer 0, timeout counter 0. Reset mid-operation aborts the query: no response is issued, and the engine is not told.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching from ptr upward and wrapping modulo NREQ.
  - Same cycle: pulse req_ready[g], latch central/radius/mode/id, set ptr = (g+1) mod NREQ.
  - If the latched mode is 11, go to RESP with err=1 and no dispatch. Otherwise go to ISSUE.
- ISSUE:
  - eng_en = 1 for exactly this one cycle. eng_central/radius/mode are driven from the latch and held stable through WAIT.
  - Next state WAIT. Clear the seen_busy flag.
- WAIT:
  - Set seen_busy when eng_busy = 1.
  - Completion is the first cycle with seen_busy = 1, eng_busy = 0 and eng_valid = 1. Capture eng_candidate and go to RESP with err=0.
  - A completion before busy has been seen is ignored, so a stale level-high eng_valid is not mistaken for the result.
- RESP:
  - rsp_valid = 1 for one cycle, carrying rsp_id, rsp_candidate and rsp_err.
  - Next state IDLE.
  - The earliest new grant is the following cycle, so back-to-back queries are spaced at least 4 + engine latency cycles apart.
- Requester contract:
  - A requester holds req_valid and its fields until req_ready.
  - Deasserting before grant withdraws the query and is legal.
- Priority:
  - Simultaneous requests are resolved by rr order only.
  - A requester granted last has lowest priority next, so no starvation occurs: every pending requester is served within NREQ grants.
- Widths: ptr and id are IDW bits, with wrap computed modulo NREQ (not 2^IDW).

Optional Feature:
- Macro: SET_ARB_TIMEOUT_EN.
- With the macro defined:
  - An IDW-independent counter of width clog2(TIMEOUT+1) counts cycles in WAIT.
  - When it reaches TIMEOUT, go to RESP with rsp_err = 1 and rsp_candidate = 0. The counter clears on entry to WAIT.
- Without the macro: WAIT lasts indefinitely and rsp_err is only set for illegal mode.

Decomposition:
- Package set_arb_pkg holds:
  - the state enum;
  - the mode constants MODE_A=2'b00, MODE_AND=2'b01, MODE_XOR=2'b10, MODE_ILL=2'b11;
  - field offsets within central/radius.
- One sub-module: rr_arbiter (NREQ-wide request vector, ptr input, one-hot grant plus encoded index, combinational).

Test Plan:
- Single query: req 0, central={4,4,6,6,0}, radius={3,2,0}, mode=00, engine model returns 29 → one rsp_valid with id=0, cand=29, err=0. eng_en pulses exactly once.
- All four requesting from reset, ptr=0 → grants in order 0,1,2,3. Requester 0 re-requests after its grant → it is served after 3, not before 1.
- Illegal mode 11 from requester 2 → rsp_valid with id=2, err=1, cand=0. eng_en is never asserted.
- eng_valid held high from the previous query (level-sticky engine) → no response until busy has risen and fallen again. The response carries the new count.
- rst asserted during WAIT → all outputs 0 next cycle, no rsp_valid. A new query afterwards completes normally with ptr=0.
- With SET_ARB_TIMEOUT_EN and TIMEOUT=10, engine busy stuck high → rsp_err=1 exactly 10 cycles after WAIT entry. A pending requester is granted the next IDLE cycle.
